// File: rtl/decode_stage.sv
// Registered decode stage for the 16-bit ISA with valid/ready handshake and a per-register write scoreboard.
// Optional feature: define DECODE_ILLEGAL_EN to flag class 11 as illegal and lock the input side until reset.
module decode_stage #(
  parameter int unsigned XLEN  = 16,
  parameter int unsigned NREG  = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [2:0]      reg_dst,
  output logic [2:0]      reg_rs1,
  output logic [2:0]      reg_rs2,
  output logic [XLEN-1:0] imm_se,
  output logic            reg_write,
  output logic            alu_src_imm,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write_back_sel,
  output logic [2:0]      comparator_ctrl,
  input  logic            wb_valid,
  input  logic [2:0]      wb_rd
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            illegal_instr
`endif
);

  localparam int unsigned REG_W  = 3;
  localparam int unsigned OFF_W  = 7;
  localparam int unsigned SEXT_W = XLEN - OFF_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0]      alu_ctrl;
    logic [2:0]      rd;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            alu_src_imm;
    logic            mem_read;
    logic            mem_write;
    logic            wb_sel;
    logic [2:0]      cmp;
  } bundle_t;

  bundle_t          dcd;
  bundle_t          bundle_q;
  logic             use_rs1;
  logic             use_rs2;
  logic             use_rd;
  logic             hazard;
  logic             accept;
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  cnt_inc;
  logic [NREG-1:0]  cnt_dec;

`ifdef DECODE_ILLEGAL_EN
  logic dcd_illegal;
  logic illegal_q;
  logic illegal_seen;
`endif

  // Field decode of the presented instruction plus which registers it reads
  always_comb begin
    dcd     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    dcd_illegal = 1'b0;
`endif
    case (in_instr[15:14])
      2'b00: begin
        dcd.rd          = in_instr[12:10];
        dcd.rs1         = in_instr[9:7];
        dcd.imm         = {{SEXT_W{in_instr[6]}}, in_instr[6:0]};
        dcd.alu_src_imm = 1'b1;
        use_rs1         = 1'b1;
        if (in_instr[13]) begin
          dcd.mem_write = 1'b1;
          dcd.rs2       = in_instr[12:10];
          use_rd        = 1'b1;
        end else begin
          dcd.mem_read  = 1'b1;
          dcd.reg_write = 1'b1;
          dcd.wb_sel    = 1'b1;
        end
      end
      2'b01: begin
        dcd.alu_ctrl  = in_instr[13:10];
        dcd.rd        = in_instr[8:6];
        dcd.rs1       = in_instr[5:3];
        dcd.rs2       = in_instr[2:0];
        dcd.reg_write = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      2'b10: begin
        case (in_instr[13:11])
          3'b111: ;
          3'b110: begin
            dcd.rd  = in_instr[4:2];
            dcd.cmp = in_instr[13:11];
            use_rd  = 1'b1;
          end
          default: begin
            dcd.rs1 = in_instr[10:8];
            dcd.rs2 = in_instr[7:5];
            dcd.rd  = in_instr[4:2];
            dcd.cmp = in_instr[13:11];
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
          end
        endcase
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        dcd_illegal = 1'b1;
`endif
      end
    endcase
  end

  // Stall on pending writes to any source, or when the destination counter is saturated
  always_comb begin
    hazard = (use_rs1 && (cnt[dcd.rs1] != '0))
          || (use_rs2 && (cnt[dcd.rs2] != '0))
          || (use_rd  && (cnt[dcd.rd]  != '0))
          || (dcd.reg_write && (cnt[dcd.rd] == CNT_MAX));
    in_ready = !hazard && (!out_valid || out_ready);
`ifdef DECODE_ILLEGAL_EN
    in_ready = in_ready && !illegal_seen;
`endif
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_inc[r] = accept && dcd.reg_write && (dcd.rd == REG_W'(r));
      cnt_dec[r] = wb_valid && (wb_rd == REG_W'(r)) && (cnt[r] != '0);
    end
  end

  // Scoreboard counters; a simultaneous issue and retire on one register cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (cnt_inc[r] && !cnt_dec[r]) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (cnt_dec[r] && !cnt_inc[r]) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // One-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bundle_q  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle_q  <= dcd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q    <= 1'b0;
      illegal_seen <= 1'b0;
    end else if (accept) begin
      illegal_q    <= dcd_illegal;
      illegal_seen <= illegal_seen || dcd_illegal;
    end
  end

  assign illegal_instr = illegal_q;
`endif

  assign alu_ctrl           = bundle_q.alu_ctrl;
  assign reg_dst            = bundle_q.rd;
  assign reg_rs1            = bundle_q.rs1;
  assign reg_rs2            = bundle_q.rs2;
  assign imm_se             = bundle_q.imm;
  assign reg_write          = bundle_q.reg_write;
  assign alu_src_imm        = bundle_q.alu_src_imm;
  assign mem_read           = bundle_q.mem_read;
  assign mem_write          = bundle_q.mem_write;
  assign reg_write_back_sel = bundle_q.wb_sel;
  assign comparator_ctrl    = bundle_q.cmp;

endmodule
